rf_alu_pc_datapath: RTL
=======================

Name: rf_alu_pc_datapath

Overview:
- Parametrised successor to the fixed 32-bit register-file/ALU/PC-adder datapath used in the single-cycle RV32 core.
- Generalised in data width, register count and PC step.
- Adds:
  - two read ports, with an immediate operand select;
  - a selectable write-back source, including the link value PC+PC_STEP;
  - a loadable PC;
  - registered ALU outputs with a valid flag and an overflow flag.
- Sits between the decoder/control unit and the branch unit.

Parameters:
- XLEN, 32, datapath and PC width.
- NREGS, 32, number of architectural registers. Must be a power of 2 and ≥2. AW = $clog2(NREGS).
- PC_STEP, 4, PC increment per advance.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the rising edge of clk).
- pc_en  in  1  advance PC by PC_STEP.
- pc_load  in  1  load pc_target into PC; overrides pc_en.
- pc_target  in  XLEN  branch/jump target.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rd_addr  in  AW  write address.
- rg_wrt_en  in  1  register write enable.
- wb_sel  in  2  write-back source: 00 write_data, 01 ALU result, 10 PC+PC_STEP, 11 reserved (no write).
- write_data  in  XLEN  external write-back data (memory load path).
- alu_src  in  1  operand B select: 0 rs2 data, 1 imm.
- imm  in  XLEN  immediate operand.
- Operation  in  4  ALU opcode.
- op_valid  in  1  ALU operation issued this cycle.
- pc  out  XLEN  current PC, registered.
- rs1_data  out  XLEN  combinational read of port 1.
- rs2_data  out  XLEN  combinational read of port 2.
- ALUResult  out  XLEN  registered ALU result.
- negative  out  1  registered ALUResult[XLEN-1].
- zero  out  1  registered (ALUResult==0).
- overflow  out  1  registered signed overflow; ADD/SUB only, else 0.
- result_valid  out  1  registered copy of op_valid.

Behaviour:
- Reset (reset==0 at a clk edge):
  - pc=RESET_PC; every register=0.
  - ALUResult=0, negative=0, zero=0, overflow=0, result_valid=0.
  - All writes and PC updates are suppressed that cycle.
  - Reset mid-operation discards any in-flight result: result_valid=0 on the next cycle.
- Register file:
  - x0 reads as 0 always; writes to x0 are ignored.
  - Reads are combinational.
  - Read-during-write to the same address returns the pre-edge value; the new value is visible the next cycle (single-cycle semantics, no bypass).
- Write-back: on the edge with rg_wrt_en=1, the register at rd_addr takes the wb_sel source.
  - ALU source = the current-cycle combinational ALU result.
  - Link source = pc+PC_STEP, taken from the pre-edge pc.
  - wb_sel=11 performs no write.
- PC update (priority order):
  - pc_load=1 → pc_target;
  - else pc_en=1 → pc+PC_STEP;
  - else hold.
  - Addition is modulo 2^XLEN (wraps silently).
- ALU: A=rs1_data; B = alu_src ? imm : rs2_data. Opcode map:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 SLL
  - 0101 SRL
  - 0110 SUB
  - 0111 SLT (signed, result 0/1)
  - 1000 SRA
  - 1001 SLTU
  - Other opcodes → result 0, overflow 0.
- Shifts use B[$clog2(XLEN)-1:0] only.
- Overflow flag:
  - ADD: sign(A)==sign(B) and sign(R)!=sign(A).
  - SUB: sign(A)!=sign(B) and sign(R)!=sign(A).
- Output register:
  - When op_valid=1, ALUResult and the flags capture the combinational result at the edge; latency 1 cycle.
  - When op_valid=0, they hold their previous values.
  - result_valid follows op_valid with 1 cycle latency.
- Simultaneous events: PC update, register write and output capture are independent and can all occur on the same edge.

Decomposition:
- Package rf_alu_pkg holds:
  - alu_op_e enum: ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SUB, ALU_SLT, ALU_SRA, ALU_SLTU;
  - wb_sel_e enum: WB_EXT, WB_ALU, WB_LINK, WB_NONE.
- One sub-module, alu_core: purely combinational, parametrised by XLEN; produces result and overflow.
- The register array, PC and output registers live in the top module.

Test Plan:
- Reset: hold reset=0 for 2 cycles with pc_en=1 and rg_wrt_en=1 → pc=0, all outputs 0, no register written; release reset → pc steps 0,4,8.
- Write and add:
  - write x1=32'h12345678 and x2=32'h00000001 (wb_sel=00);
  - issue op_valid with Operation=0010, rs1=1, rs2=2;
  - next cycle → ALUResult=32'h12345679, negative=0, zero=0, result_valid=1.
- Overflow, sign and zero:
  - x1=32'h7FFFFFFF, imm=1, alu_src=1, ADD → ALUResult=32'h80000000, negative=1, overflow=1;
  - SUB with x1 against itself → ALUResult=0, zero=1, overflow=0.
- x0 and read-during-write:
  - write 32'hDEADBEEF to x0 → rs1_data at x0 stays 0;
  - write x3=5 while reading x3 → old value that cycle, 5 next cycle.
- PC control:
  - pc_en and pc_load both high with target 32'h100 → pc=32'h100;
  - from pc=32'hFFFFFFFC with pc_en → pc=0 (wrap);
  - wb_sel=10 to x1 at pc=32'h100 → x1=32'h104.
- Parametrisation: build with XLEN=16, NREGS=8 → SRA of 16'h8000 by imm=15 gives 16'hFFFF; SLTU(1, 16'hFFFF)=1; SLT(1, 16'hFFFF)=0.

Source files
------------

// File: rtl/rf_alu_pc_datapath_pkg.sv
// Shared types for the register-file / ALU / PC datapath.
//   alu_op_e : 4-bit ALU opcode encoding.
//   wb_sel_e : 2-bit write-back source select.
//   add_overflow() : signed-overflow rule for an addition.
package rf_alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_EXT  = 2'b00,
        WB_ALU  = 2'b01,
        WB_LINK = 2'b10,
        WB_NONE = 2'b11
    } wb_sel_e;

    // Overflow when both operands share a sign and the result does not.
    // Subtraction reuses this by passing the inverted sign of B.
    function automatic logic add_overflow(input logic sign_a, input logic sign_b,
                                          input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/rf_alu_pc_datapath_alu_core.sv
// Purely combinational ALU.
//   a, b     : operands (XLEN)
//   op       : opcode (alu_op_e encoding); unknown opcodes give 0
//   result   : XLEN result
//   overflow : signed overflow, ADD/SUB only
module alu_core
    import rf_alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] result,
    output logic            overflow
);

    localparam int unsigned SW = $clog2(XLEN);

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [SW-1:0]   shamt;

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[SW-1:0];

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD: begin
                result   = sum;
                overflow = add_overflow(a[XLEN-1], b[XLEN-1], sum[XLEN-1]);
            end
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SUB: begin
                result   = diff;
                overflow = add_overflow(a[XLEN-1], ~b[XLEN-1], diff[XLEN-1]);
            end
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            default: begin
                result   = '0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rf_alu_pc_datapath.sv
// Register file + ALU + PC datapath for the single-cycle core.
//   clk, reset (sync, active-low)
//   pc_en / pc_load / pc_target : PC advance / load (load wins)
//   rs1_addr, rs2_addr -> rs1_data, rs2_data : combinational reads, x0 = 0
//   rd_addr, rg_wrt_en, wb_sel, write_data   : write-back port
//   alu_src, imm, Operation, op_valid        : ALU issue
//   pc, ALUResult, negative, zero, overflow, result_valid : registered outputs
module rf_alu_pc_datapath
    import rf_alu_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREGS    = 32,
    parameter int unsigned     PC_STEP  = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pc_en,
    input  logic                     pc_load,
    input  logic [XLEN-1:0]          pc_target,
    input  logic [$clog2(NREGS)-1:0] rs1_addr,
    input  logic [$clog2(NREGS)-1:0] rs2_addr,
    input  logic [$clog2(NREGS)-1:0] rd_addr,
    input  logic                     rg_wrt_en,
    input  logic [1:0]               wb_sel,
    input  logic [XLEN-1:0]          write_data,
    input  logic                     alu_src,
    input  logic [XLEN-1:0]          imm,
    input  logic [3:0]               Operation,
    input  logic                     op_valid,
    output logic [XLEN-1:0]          pc,
    output logic [XLEN-1:0]          rs1_data,
    output logic [XLEN-1:0]          rs2_data,
    output logic [XLEN-1:0]          ALUResult,
    output logic                     negative,
    output logic                     zero,
    output logic                     overflow,
    output logic                     result_valid
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] pc_plus;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_res;
    logic            alu_ovf;
    logic [XLEN-1:0] wb_data;
    logic            wb_we;

    assign pc_plus  = pc + STEP;
    assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
    assign alu_b    = alu_src ? imm : rs2_data;

    alu_core #(.XLEN(XLEN)) u_alu (
        .a        (rs1_data),
        .b        (alu_b),
        .op       (Operation),
        .result   (alu_res),
        .overflow (alu_ovf)
    );

    always_comb begin
        wb_data = '0;
        wb_we   = rg_wrt_en;
        case (wb_sel)
            WB_EXT:  wb_data = write_data;
            WB_ALU:  wb_data = alu_res;
            WB_LINK: wb_data = pc_plus;
            default: wb_we   = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc           <= RESET_PC;
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
            ALUResult    <= '0;
            negative     <= 1'b0;
            zero         <= 1'b0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            if (pc_load)    pc <= pc_target;
            else if (pc_en) pc <= pc_plus;

            if (wb_we && (rd_addr != '0)) regs[rd_addr] <= wb_data;

            if (op_valid) begin
                ALUResult <= alu_res;
                negative  <= alu_res[XLEN-1];
                zero      <= (alu_res == '0);
                overflow  <= alu_ovf;
            end
            result_valid <= op_valid;
        end
    end

endmodule
